// File: rtl/rot_iter.sv
// Iterative barrel rotator: one power-of-two rotation stage per clock, MSB of the
// amount first, with a valid/ready request side and a valid/ready result side.
module rot_iter #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic                     in_dir,
  input  logic                     abort,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data
);

  localparam int AW = $clog2(WIDTH);
  localparam int KW = $clog2(AW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  logic [KW-1:0]   k_reg;
  logic [WIDTH-1:0] work_reg;
  logic [AW-1:0]   amt_reg;
  logic            dir_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;

  // Stage k handles amount bit AW-1-k, i.e. a rotation by 2^(AW-1-k).
  logic [KW-1:0]    bit_idx;
  logic [WIDTH-1:0] rotl [AW];
  logic [WIDTH-1:0] rotr [AW];

  assign bit_idx = KW'(AW - 1) - k_reg;

  for (genvar gi = 0; gi < AW; gi++) begin : g_stage
    localparam int S = 2 ** gi;
    assign rotl[gi] = {work_reg[WIDTH-1-S:0], work_reg[WIDTH-1:WIDTH-S]};
    assign rotr[gi] = {work_reg[S-1:0], work_reg[WIDTH-1:S]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      work_reg      <= '0;
      amt_reg       <= '0;
      dir_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (in_valid) begin
            work_reg     <= in_data;
            amt_reg      <= in_amt;
            dir_reg      <= in_dir;
            k_reg        <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= ROT;
          end
        end
        ROT: begin
          if (abort) begin
            k_reg        <= '0;
            in_ready_reg <= 1'b1;
            state_reg    <= IDLE;
          end else begin
            if (amt_reg[bit_idx]) begin
              work_reg <= dir_reg ? rotr[bit_idx] : rotl[bit_idx];
            end
            if (k_reg == KW'(AW - 1)) begin
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              k_reg <= k_reg + KW'(1);
            end
          end
        end
        DONE: begin
          // abort is deliberately not looked at here: a finished result is always delivered.
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            k_reg         <= '0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = work_reg;

endmodule

// File: tb/tb_rot_iter.sv
// Self-checking bench for rot_iter (WIDTH=32) against a doubled-word rotation model.
module tb_rot_iter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic        in_dir;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks;
  int failures;

  rot_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rol_ref(input logic [31:0] x, input int n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] ror_ref(input logic [31:0] x, input int n);
    logic [63:0] t;
    t = {x, x} >> n;
    return t[31:0];
  endfunction

  // Called 1 time unit after a rising edge with the DUT idle.
  task automatic run_op(input logic [31:0] d, input logic [4:0] n, input logic dir,
                        input logic release_out, output logic [31:0] res, output int lat);
    in_data  = d;
    in_amt   = n;
    in_dir   = dir;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_amt   = 5'($urandom);
    in_dir   = ~dir;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      checks++; failures++;
      $display("FAIL op_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    end
    res = out_data;
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #13;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h, required 1 0 00000000",
               in_ready, out_valid, out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset released: in_ready=%b out_valid=%b", in_ready, out_valid);
  endtask

  task automatic test_directed();
    logic [31:0] res;
    int lat;
    logic [31:0] dv [4] = '{32'h12345678, 32'h00000001, 32'h80000000, 32'hDEADBEEF};
    logic [4:0]  nv [4] = '{5'd8, 5'd1, 5'd31, 5'd0};
    logic        rv [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ev [4] = '{32'h34567812, 32'h80000000, 32'h40000000, 32'hDEADBEEF};
    for (int i = 0; i < 4; i++) begin
      run_op(dv[i], nv[i], rv[i], 1'b1, res, lat);
      checks++;
      if (res !== ev[i] || lat != 5) begin
        failures++;
        $display("FAIL directed_%0d: out_data=%h latency=%0d, required %h latency=5", i, res, lat, ev[i]);
      end
      $display("directed %0d: data=%h amt=%0d dir=%b -> %h lat=%0d", i, dv[i], nv[i], rv[i], res, lat);
    end
    run_op(32'hDEADBEEF, 5'd0, 1'b1, 1'b1, res, lat);
    checks++;
    if (res !== 32'hDEADBEEF || lat != 5) begin
      failures++;
      $display("FAIL amt0_right: out_data=%h latency=%0d, required deadbeef latency=5", res, lat);
    end
    $display("amt0 right: %h lat=%0d", res, lat);
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    logic [31:0] exp;
    int lat;
    exp = rol_ref(32'hCAFEF00D, 13);
    run_op(32'hCAFEF00D, 5'd13, 1'b0, 1'b0, res, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_amt   = 5'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_data !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold_%0d: out_data=%h out_valid=%b in_ready=%b, required %h 1 0",
                 i, out_data, out_valid, in_ready, exp);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_ignored_req: out_valid=%b at cycle %0d, required 0", out_valid, i);
      end
    end
    $display("backpressure: held %h for 10 cycles, released", exp);
  endtask

  task automatic test_abort();
    in_data = 32'hA5A5_0F0F; in_amt = 5'd7; in_dir = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_return: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_valid: out_valid=%b at cycle %0d, required 0", out_valid, i);
      end
    end
    $display("abort at step 2: in_ready=%b out_valid=%b", in_ready, out_valid);
  endtask

  task automatic test_abort_done();
    logic [31:0] res;
    logic [31:0] exp;
    int lat;
    exp = ror_ref(32'h0123_4567, 9);
    run_op(32'h0123_4567, 5'd9, 1'b1, 1'b0, res, lat);
    abort = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        failures++;
        $display("FAIL abort_in_done: out_valid=%b out_data=%h, required 1 %h", out_valid, out_data, exp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_done_handshake: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    $display("abort in DONE ignored, handshake completed: %h", exp);
  endtask

  task automatic test_reset_mid_rot();
    logic [31:0] res;
    int lat;
    in_data = 32'h7777_1234; in_amt = 5'd19; in_dir = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_async: in_ready=%b out_valid=%b out_data=%h, required 1 0 00000000",
               in_ready, out_valid, out_data);
    end
    #2;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_drop: out_valid=%b in_ready=%b at cycle %0d, required 0 1", out_valid, in_ready, i);
      end
    end
    // Second pulse: request is presented for the very first edge after release.
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    run_op(32'hF00D_BABE, 5'd4, 1'b0, 1'b1, res, lat);
    checks++;
    if (res !== rol_ref(32'hF00D_BABE, 4) || lat != 5) begin
      failures++;
      $display("FAIL reset_first_edge: out_data=%h latency=%0d, required %h latency=5",
               res, lat, rol_ref(32'hF00D_BABE, 4));
    end
    $display("reset mid-ROT dropped op; first-edge accept -> %h lat=%0d", res, lat);
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  n;
    int lat1;
    int lat2;
    int bad;
    for (int i = 0; i < 1000; i++) begin
      d = $urandom;
      n = 5'($urandom_range(0, 31));
      run_op(d, n, 1'b0, 1'b1, r1, lat1);
      run_op(r1, n, 1'b1, 1'b1, r2, lat2);
      bad = 0;
      checks++;
      if (r1 !== rol_ref(d, int'(n)) || lat1 != 5) begin
        failures++; bad = 1;
        $display("FAIL random_rol_%0d: data=%h amt=%0d out=%h lat=%0d, required %h lat=5",
                 i, d, n, r1, lat1, rol_ref(d, int'(n)));
      end
      checks++;
      if (r2 !== d || r2 !== ror_ref(r1, int'(n)) || lat2 != 5) begin
        failures++; bad = 1;
        $display("FAIL random_ror_%0d: data=%h amt=%0d out=%h lat=%0d, required %h lat=5",
                 i, r1, n, r2, lat2, d);
      end
      $display("random %0d: data=%h amt=%0d rol=%h ror=%h %s", i, d, n, r1, r2, bad ? "bad" : "ok");
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_dir    = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_abort_done();
    test_reset_mid_rot();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rot_iter.md
ROT_ITER -- requirements
Module: rot_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; legal values 8, 16, 32 and 64.
REQ-002 SHALL derive local constant AW = log2(WIDTH), the amount width and the step count (5 for WIDTH=32).
REQ-003 SHALL have port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, request valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 SHALL have port in_data, input, WIDTH, operand.
REQ-008 SHALL have port in_amt, input, AW, rotate amount.
REQ-009 SHALL have port in_dir, input, 1, direction: 0 = rotate left, 1 = rotate right.
REQ-010 SHALL have port abort, input, 1, synchronous cancel of the operation in flight.
REQ-011 SHALL have port out_valid, output, 1, result valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-013 SHALL have port out_data, output, WIDTH, rotated result.

Function
REQ-014 SHALL implement the three-state FSM IDLE, ROT and DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE.
REQ-016 SHALL accept a request on an edge where in_valid and in_ready are both 1.
- The accepting edge captures in_data, in_amt and in_dir.
- It clears step counter k and enters ROT.
REQ-017 SHALL perform one step per clock in ROT, for k = 0 .. AW-1.
- If bit (AW-1-k) of the captured amount is set, rotate the working register by 2^(AW-1-k) positions in the captured direction; otherwise hold it.
REQ-018 SHALL use rotation only: bits leaving one end re-enter the other end, with no fill and no loss.
REQ-019 SHALL move from ROT to DONE on the edge that completes step AW-1.
- Latency: out_valid rises exactly AW cycles after the accepting edge (5 for WIDTH=32).
- Latency is the same for every amount, including 0.
REQ-020 SHALL drive out_data from the working register and hold it stable throughout DONE.
REQ-021 SHALL stay in DONE while out_ready = 0, and move to IDLE on the edge where out_ready = 1.
REQ-022 SHALL ignore in_valid outside IDLE; back-to-back requests are therefore spaced at least AW+2 cycles apart.
REQ-023 SHALL, when abort = 1 in ROT, return to IDLE on the next edge and discard the result; out_valid SHALL never assert for an aborted request.
REQ-024 SHALL ignore abort in IDLE and in DONE.
REQ-025 SHALL, when abort and out_ready are both 1 in DONE, complete the handshake normally.
REQ-026 SHALL produce, for amount 0, out_data equal to in_data in both directions.
REQ-027 SHALL satisfy ROR(x, n) = ROL(x, (WIDTH-n) mod WIDTH) for every x and n.

Reset
REQ-028 SHALL, while rst = 1 and independent of clk, force:
- state = IDLE and k = 0;
- working register = 0 and out_data = 0;
- out_valid = 0 and in_ready = 1 (in_ready rises immediately).
REQ-029 SHALL, when rst asserts in ROT or DONE, drop the pending operation; no out_valid SHALL follow its release.
REQ-030 SHALL accept a new request on the first rising edge after rst deasserts.

Verification (WIDTH=32)
REQ-031 Bench SHALL cover: rotate left, amount 8, data 0x12345678 -> out_data 0x34567812; out_valid rises 5 cycles after accept.
REQ-032 Bench SHALL cover: rotate right, amount 1, data 0x00000001 -> 0x80000000; rotate left, amount 31, data 0x80000000 -> 0x40000000.
REQ-033 Bench SHALL cover: amount 0 in both directions, data 0xDEADBEEF -> 0xDEADBEEF after 5 cycles.
REQ-034 Bench SHALL cover backpressure:
- hold out_ready = 0 for 10 cycles in DONE -> out_data stable and in_ready = 0 throughout;
- a new in_valid during that time is ignored;
- after out_ready = 1 -> IDLE on the next edge.
REQ-035 Bench SHALL cover: abort at ROT step 2, then rst asserted mid-ROT in a second run -> no out_valid in either case; in_ready returns to 1 (immediately for rst, next edge for abort).
REQ-036 Bench SHALL cover: 1000 random (data, amount) pairs; rotate left by n then rotate right by n -> original data; every result matches the reference rotation model.
